keypad_event_scanner: RTL and testbench
=======================================

KEYPAD_EVENT_SCANNER -- requirements
Module: keypad_event_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad row sense lines.
REQ-002 SHALL have parameter COLS, default 4, number of keypad column drive lines.
REQ-003 SHALL have parameter SCAN_DIV, default 500, clocks per column dwell.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 10000, stable clocks required for press and for release.
REQ-005 SHALL have parameter REPEAT_DELAY, default 25000000, clocks held before first auto-repeat.
REQ-006 SHALL have parameter REPEAT_RATE, default 5000000, clocks between subsequent auto-repeats.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, power of two; event queue entries.
REQ-008 SHALL have CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-009 SHALL have Reset  input  1  reset, synchronous, active-low.
REQ-010 SHALL have col_drive  output  COLS  active-low one-hot column strobe.
REQ-011 SHALL have row_sense  input  ROWS  active-low row returns, externally pulled high, double-flop synchronised internally.
REQ-012 SHALL have repeat_en  input  1  enables auto-repeat events.
REQ-013 SHALL have key_ack  input  1  pops head event when key_valid=1.
REQ-014 SHALL have key_code  output  CW=ceil(log2(ROWS*COLS))  head event code, row*COLS+col.
REQ-015 SHALL have key_rep  output  1  head event is an auto-repeat (0 = initial press).
REQ-016 SHALL have key_valid  output  1  FIFO non-empty.
REQ-017 SHALL have key_held  output  1  debounced key currently down.
REQ-018 SHALL have overflow  output  1  sticky: an event was dropped.

Function
REQ-019 Scanner SHALL drive exactly one column low; it SHALL advance col 0..COLS-1 then wrap to 0, every SCAN_DIV clocks, only while all synchronised rows are high.
REQ-020 While any row is low, the scanner SHALL freeze on the current column.
REQ-021 Raw detect SHALL be valid only when exactly one row is low; raw code = row_index*COLS+current_col; zero or multiple rows low = raw invalid (ghost rejection).
REQ-022 Debounce FSM states SHALL be IDLE, DEBOUNCE, HELD, REPEAT.
REQ-023 IDLE: raw valid -> latch code, load counter DEBOUNCE_CYCLES-1, go DEBOUNCE.
REQ-024 DEBOUNCE: raw invalid or code differs from latched -> IDLE, no event; counter 0 with raw still matching -> push {code,rep=0}, go HELD.
REQ-025 HELD/REPEAT: raw invalid for DEBOUNCE_CYCLES consecutive clocks -> IDLE; any valid matching sample restarts release count; a different valid code is treated as still-held (no event).
REQ-026 HELD with repeat_en=1: after REPEAT_DELAY clocks in HELD -> push {code,rep=1}, go REPEAT; REPEAT pushes {code,rep=1} every REPEAT_RATE clocks.
REQ-027 repeat_en deasserted in REPEAT SHALL return FSM to HELD with no further repeats; delay timer restarts.
REQ-028 key_held SHALL be 1 exactly in HELD and REPEAT.
REQ-029 FIFO SHALL be FIFO_DEPTH deep, CW+1 wide, first-word-fall-through; key_code/key_rep reflect head combinationally from storage.
REQ-030 Pop SHALL occur on key_ack&key_valid; key_ack when empty SHALL be ignored.
REQ-031 Push when full and no pop SHALL drop the new event and set overflow; push and pop in same clock when full SHALL both succeed, no overflow.
REQ-032 Push and pop in same clock when empty: push succeeds, key_valid=1 next clock.
REQ-033 Pointer wrap SHALL be modulo FIFO_DEPTH with an extra bit distinguishing full from empty.
REQ-034 Event latency: push visible on key_valid one clock after the DEBOUNCE counter reaches 0.

Reset
REQ-035 On Reset=0 at a clock edge: col_drive = all ones except bit 0 low, FSM IDLE, all counters 0, FIFO empty, key_valid=0, key_held=0, overflow=0, key_code=0, key_rep=0.
REQ-036 Reset mid-debounce, mid-hold or with FIFO occupied SHALL discard all state; no event is emitted for a key already down until it is re-debounced from IDLE.
REQ-037 overflow SHALL clear only on reset.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=16, FIFO_DEPTH=4)
REQ-038 Press row 2/col 1 held 100 clocks, repeat_en=0 -> exactly one event key_code=9, key_rep=0; key_held drops 8 clocks after release.
REQ-039 Press bouncing every 5 clocks for 50 clocks then stable -> one event only, after stable 8 clocks.
REQ-040 Hold key 0 with repeat_en=1 for 100 clocks, ack each -> events rep=0, then rep=1 at +40 and +56 and +72 after press event.
REQ-041 Rows 1 and 3 low simultaneously -> no event, key_held=0.
REQ-042 Five presses, no ack -> four events retained (first four codes), overflow=1; ack while full plus new press same clock -> no overflow change, entry count stays 4.
REQ-043 Reset asserted with 3 queued events and key held -> key_valid=0, overflow=0, col_drive=1110 next clock; key re-reported after 8 stable clocks.

Source files
------------

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: column strobe, ghost-rejecting single-key debounce,
//   press and auto-repeat events queued in a small first-word-fall-through FIFO.
// Latency: event reaches key_valid one clock after the debounce count expires.
//   Backpressure: a full queue with no key_ack drops the new event and sets sticky overflow.
// Ports: CLOCK_50/Reset (synchronous, active-low); col_drive strobes one column low;
//   row_sense returns active-low rows; repeat_en gates auto-repeat; key_ack pops
//   the head {key_code,key_rep} while key_valid; key_held marks a debounced key down.

// Event queue: FIFO_DEPTH x W storage, head readable combinationally.
// Latency: pushed word visible on valid the clock after the push.
// Backpressure: push while full without a pop is dropped and flagged in overflow.
module keypad_event_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic         overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         empty, full, do_pop, do_push;

    // The extra pointer bit tells a full queue from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A same-clock pop frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Storage is not reset, so the head is masked while empty.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign valid     = !empty;
endmodule

module keypad_event_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 500,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int FIFO_DEPTH      = 4,
    localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            CLOCK_50,
    input  logic            Reset,
    output logic [COLS-1:0] col_drive,
    input  logic [ROWS-1:0] row_sense,
    input  logic            repeat_en,
    input  logic            key_ack,
    output logic [CW-1:0]   key_code,
    output logic            key_rep,
    output logic            key_valid,
    output logic            key_held,
    output logic            overflow
);
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SDW  = $clog2(SCAN_DIV + 1);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW  = $clog2(RMAX + 1);

    localparam logic [SDW-1:0] DIV_LAST  = SDW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPW-1:0] DLY_LAST  = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RATE_LAST = RPW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;

    logic [ROWS-1:0] rs_meta, rows_s;
    logic [CLW-1:0]  col;
    logic [SDW-1:0]  dcnt;
    logic [RW-1:0]   row_idx;
    logic            raw_vld, match;
    logic [CW-1:0]   raw_code;

    state_t          state_q, state_d;
    logic [CW-1:0]   code_q, code_d;
    logic [DBW-1:0]  cnt_q, cnt_d;
    logic [RPW-1:0]  rcnt_q, rcnt_d;
    logic            push, push_rep;
    logic [CW:0]     head;

    // Idle rows read high, so the synchroniser resets to all ones.
    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            rs_meta <= '1;
            rows_s  <= '1;
        end else begin
            rs_meta <= row_sense;
            rows_s  <= rs_meta;
        end
    end

    // Column strobe dwells SCAN_DIV clocks and freezes while any row is low.
    // SCAN_DIV must exceed the two-flop sync delay so a key found on the
    // new column freezes the scan before it moves on.
    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            col  <= '0;
            dcnt <= '0;
        end else if (&rows_s) begin
            if (dcnt == DIV_LAST) begin
                dcnt <= '0;
                col  <= (col == CLW'(COLS - 1)) ? '0 : col + 1'b1;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign col_drive = ~(COLS'(1) << col);

    always_comb begin
        row_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!rows_s[r]) row_idx = RW'(r);
        end
    end

    // Zero or several low rows is ambiguous (ghosting) and reads as no key.
    assign raw_vld  = $onehot(~rows_s);
    assign raw_code = CW'(row_idx) * CW'(COLS) + CW'(col);
    assign match    = raw_vld && (raw_code == code_q);

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // cnt_q is the press count in DEBOUNCE and the release count once held;
    // rcnt_q times the repeat delay in HELD and the repeat period in REPEAT.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        push     = 1'b0;
        push_rep = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (raw_vld) begin
                    code_d  = raw_code;
                    cnt_d   = DEB_LAST;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!match) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    push    = 1'b1;
                    state_d = HELD;
                    cnt_d   = DEB_LAST;
                    rcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HELD, REPEAT: begin
                // Any valid sample, even another key, keeps the key held.
                if (raw_vld)            cnt_d = DEB_LAST;
                else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;

                if (!raw_vld && cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                end else if (!repeat_en) begin
                    state_d = HELD;
                    rcnt_d  = '0;
                end else if (rcnt_q == ((state_q == HELD) ? DLY_LAST : RATE_LAST)) begin
                    push     = 1'b1;
                    push_rep = 1'b1;
                    state_d  = REPEAT;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_held = (state_q == HELD) || (state_q == REPEAT);

    keypad_event_fifo #(
        .W     (CW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .push      (push),
        .push_data ({code_q, push_rep}),
        .pop       (key_ack),
        .head_data (head),
        .valid     (key_valid),
        .overflow  (overflow)
    );

    assign key_code = head[CW:1];
    assign key_rep  = head[0];
endmodule

// File: tb/tb_keypad_event_scanner.sv
// Bench for keypad_event_scanner: keypad matrix model, scoreboard of expected
//   events fed by the stimulus, and an independent monitor that pops and acks.
module tb_keypad_event_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEB = 8;
    localparam int RDLY = 40, RRATE = 16, DEPTH = 4, CW = 4;

    logic            CLOCK_50 = 1'b0;
    logic            Reset;
    logic [COLS-1:0] col_drive;
    logic [ROWS-1:0] row_sense;
    logic            repeat_en;
    logic            key_ack;
    logic [CW-1:0]   key_code;
    logic            key_rep, key_valid, key_held, overflow;

    logic [ROWS*COLS-1:0] keys;
    logic mon_ack, stim_ack, auto_ack;
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   n_seen = 0, last_evt = 0;

    typedef struct {
        int code;
        int rep;
        int dly;   // required clocks since previous event, 0 = not checked
    } exp_t;
    exp_t exp_q[$];

    keypad_event_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .col_drive(col_drive),
        .row_sense(row_sense), .repeat_en(repeat_en), .key_ack(key_ack),
        .key_code(key_code), .key_rep(key_rep), .key_valid(key_valid),
        .key_held(key_held), .overflow(overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    assign key_ack = mon_ack | stim_ack;

    // Switch matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sense[r] = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !col_drive[c]) row_sense[r] = 1'b0;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    function automatic int col_index(input logic [COLS-1:0] cd);
        int idx = -1;
        for (int c = 0; c < COLS; c++) if (!cd[c]) idx = c;
        return idx;
    endfunction

    // Monitor: every presented event is compared with the scoreboard head.
    initial begin
        exp_t e;
        int   d;
        mon_ack = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            mon_ack = 1'b0;
            if (auto_ack && key_valid) begin
                d = cyc - last_evt;
                if (exp_q.size() == 0) begin
                    check("unexpected_event_code", int'(key_code), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("event_code", int'(key_code), e.code);
                    check("event_rep", int'(key_rep), e.rep);
                    if (e.dly != 0) check("event_spacing", d, e.dly);
                end
                last_evt = cyc;
                n_seen++;
                mon_ack = 1'b1;
            end
        end
    end

    task automatic wait_event(input int seen0, input int budget, input string name);
        int k = 0;
        while (n_seen == seen0 && k < budget) begin tick(); k++; end
        check(name, int'(n_seen != seen0), 1);
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        int k = 0;
        while (key_held !== v && k < budget) begin tick(); k++; end
        check(name, int'(key_held), int'(v));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin tick(); k++; end
        check(name, exp_q.size(), 0);
    endtask

    // One key press of rel clocks past its press event; reference expectations
    // come straight from the timing rules: press, then repeats at +RDLY, +RRATE...
    task automatic session(input int r, input int c, input logic ren, input int nrep, input int rel);
        int code = r * COLS + c;
        int seen0 = n_seen;
        int p;
        exp_q.push_back('{code, 0, 0});
        for (int k = 0; k < nrep; k++) exp_q.push_back('{code, 1, (k == 0) ? RDLY : RRATE});
        repeat_en = ren;
        keys[code] = 1'b1;
        wait_event(seen0, 300, "press_event_seen");
        p = last_evt;
        while (cyc < p + rel) tick();
        keys[code] = 1'b0;
        while (cyc < p + rel + 9) tick();
        check("held_until_release_debounced", int'(key_held), 1);
        tick();
        check("held_drops_after_release", int'(key_held), 0);
        repeat (5) tick();
        repeat_en = 1'b0;
        wait_drain(20, "session_events_delivered");
    endtask

    // Press, release, no ack: used to fill the queue.
    task automatic press_unacked(input int code, input string name);
        keys[code] = 1'b1;
        wait_held(1'b1, 300, name);
        keys[code] = 1'b0;
        wait_held(1'b0, 40, "release_unacked");
    endtask

    initial begin
        int prev, cur, run, changes, r, c, mode, nrep, rel, code, q, y, a;
        Reset = 1'b0; keys = '0; repeat_en = 1'b0; stim_ack = 1'b0; auto_ack = 1'b0;
        repeat (3) tick();
        check("rst_col_drive", int'(col_drive), 14);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_rep", int'(key_rep), 0);
        Reset = 1'b1;
        auto_ack = 1'b1;

        // Idle scan: one column low, stepping in order every SCAN_DIV clocks.
        prev = col_index(col_drive); run = 0; changes = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            check("scan_one_low", $countones(~col_drive), 1);
            cur = col_index(col_drive);
            if (cur != prev) begin
                check("scan_order", cur, (prev + 1) % COLS);
                if (changes > 0) check("scan_dwell", run, SCAN_DIV);
                changes++; run = 1; prev = cur;
            end else begin
                run++;
            end
        end

        // Row 2 / col 1 held long without repeat: a single code-9 press event.
        session(2, 1, 1'b0, 0, 90);
        // Key 0 with repeat: press, then repeats 40, 56, 72 clocks after it.
        session(0, 0, 1'b1, 3, 74);

        // Bouncing contact first, then a stable press: exactly one event.
        r = $urandom_range(0, ROWS-1); c = $urandom_range(0, COLS-1);
        for (int i = 0; i < 5; i++) begin
            keys[r*COLS+c] = 1'b1; repeat (5) tick();
            keys[r*COLS+c] = 1'b0; repeat (5) tick();
        end
        session(r, c, 1'b0, 0, 20);

        // Ghost: two rows low on one column is rejected, scan stays frozen there.
        c = $urandom_range(0, COLS-1);
        keys[1*COLS+c] = 1'b1; keys[3*COLS+c] = 1'b1;
        begin
            int held_seen = 0;
            for (int i = 0; i < 80; i++) begin tick(); if (key_held) held_seen = 1; end
            check("ghost_never_held", held_seen, 0);
        end
        check("ghost_scan_frozen", col_index(col_drive), c);
        keys = '0;
        repeat (20) tick();

        // Randomised sessions.
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, ROWS-1); c = $urandom_range(0, COLS-1);
            mode = $urandom_range(0, 2);
            if (mode == 0)      session(r, c, 1'b0, 0, $urandom_range(3, 60));
            else if (mode == 1) session(r, c, 1'b1, 0, $urandom_range(3, 25));
            else begin
                nrep = $urandom_range(1, 3);
                session(r, c, 1'b1, nrep, RDLY + RRATE*(nrep-1) + $urandom_range(1, 3));
            end
        end

        // Dropping repeat_en in REPEAT returns to HELD; re-enabling restarts the delay.
        r = $urandom_range(0, ROWS-1); c = $urandom_range(0, COLS-1); code = r*COLS + c;
        exp_q.push_back('{code, 0, 0});
        exp_q.push_back('{code, 1, RDLY});
        repeat_en = 1'b1;
        keys[code] = 1'b1;
        wait_event(n_seen, 300, "restart_press_seen");
        wait_event(n_seen, 60, "restart_first_repeat_seen");
        q = last_evt;
        repeat_en = 1'b0;
        y = cyc + 20;
        exp_q.push_back('{code, 1, y + RDLY - q});
        while (cyc < y) tick();
        repeat_en = 1'b1;
        while (cyc < y + RDLY + 2) tick();
        keys[code] = 1'b0;
        wait_held(1'b0, 20, "restart_release");
        repeat_en = 1'b0;
        wait_drain(20, "restart_events_delivered");

        // Overflow: five presses unacked keep the first four and flag overflow.
        auto_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            code = $urandom_range(0, ROWS*COLS-1);
            if (i < 4) exp_q.push_back('{code, 0, 0});
            press_unacked(code, "fill_press_held");
            if (i == 3) check("no_overflow_at_four", int'(overflow), 0);
        end
        check("overflow_after_fifth", int'(overflow), 1);
        check("full_key_valid", int'(key_valid), 1);

        // Ack on the exact clock a new press event is pushed into the full queue.
        c = (col_index(col_drive) + 2) % COLS;
        r = $urandom_range(0, ROWS-1); code = r*COLS + c;
        keys[code] = 1'b1;
        a = -1;
        for (int k = 0; k < 40 && a < 0; k++) begin
            tick();
            if (col_index(col_drive) == c) a = cyc;
        end
        check("target_column_reached", int'(a >= 0), 1);
        while (cyc < a + 10) tick();
        check("head_before_pop", int'(key_code), exp_q[0].code);
        void'(exp_q.pop_front());
        exp_q.push_back('{code, 0, 0});
        stim_ack = 1'b1;
        tick();
        stim_ack = 1'b0;
        check("push_on_pop_clock", int'(key_held), 1);
        check("overflow_unchanged", int'(overflow), 1);
        keys[code] = 1'b0;
        wait_held(1'b0, 40, "push_pop_release");
        auto_ack = 1'b1;
        wait_drain(30, "four_entries_after_push_pop");
        tick();
        check("drained_key_valid", int'(key_valid), 0);

        // Reset with events queued and a key down discards everything.
        auto_ack = 1'b0;
        for (int i = 0; i < 2; i++) press_unacked($urandom_range(0, ROWS*COLS-1), "rst_fill_held");
        code = $urandom_range(0, ROWS*COLS-1);
        keys[code] = 1'b1;
        wait_held(1'b1, 300, "rst_key_down_held");
        check("overflow_sticky", int'(overflow), 1);
        Reset = 1'b0;
        tick();
        check("midrst_key_valid", int'(key_valid), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_col_drive", int'(col_drive), 14);
        check("midrst_key_held", int'(key_held), 0);
        exp_q.delete();
        Reset = 1'b1;
        exp_q.push_back('{code, 0, 0});
        auto_ack = 1'b1;
        wait_drain(300, "rereport_after_reset");
        keys = '0;
        wait_held(1'b0, 40, "final_release");
        repeat (10) tick();
        check("no_leftover_expectations", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
